// File: rtl/tdm_line_mux.sv
// Four-line TDM multiplexer: snapshots L on start and drives each line on P for HOLD_CYCLES cycles.
// Define LINE_MUX_AUTO_EN for continuous scanning (DONE recaptures L and restarts without start).
module tdm_line_mux #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [0:3] L,
    output logic       P,
    output logic [1:0] LB,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [0:3] snap_q, snap_d;
    logic [1:0] lb_q, lb_d;
    logic [3:0] hold_q, hold_d;
    logic       p_q, p_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        lb_d    = lb_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                lb_d   = 2'd0;
                hold_d = 4'd0;
                if (start) begin
                    state_d = SEND;
                    snap_d  = L;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = 4'd0;
                    if (lb_q == 2'd3) begin
                        state_d = DONE;
                        lb_d    = 2'd0;
                    end else begin
                        lb_d = lb_q + 2'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                lb_d   = 2'd0;
                hold_d = 4'd0;
`ifdef LINE_MUX_AUTO_EN
                state_d = SEND;
                snap_d  = L;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
                snap_d  = 4'b0000;
                lb_d    = 2'd0;
                hold_d  = 4'd0;
            end
        endcase

        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        if (valid_d) begin
            p_d = snap_d[lb_d];
        end else begin
            p_d = 1'b0;
        end
    end

    // State, snapshot, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= 4'b0000;
            lb_q    <= 2'd0;
            hold_q  <= 4'd0;
            p_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            lb_q    <= lb_d;
            hold_q  <= hold_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign P     = p_q;
    assign LB    = lb_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tdm_line_mux.sv
// Directed, table-driven bench for tdm_line_mux (HOLD_CYCLES=1 and HOLD_CYCLES=3 instances).
module tb_tdm_line_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start3;
    logic [0:3] L1, L3;
    logic       P1, P3;
    logic [1:0] LB1, LB3;
    logic       valid1, valid3, busy1, busy3, done1, done3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       start;
        logic [0:3] l;
        logic [1:0] lb;
        logic       p;
        logic       valid;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt[18];

    tdm_line_mux #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .L(L1),
        .P(P1), .LB(LB1), .valid(valid1), .busy(busy1), .done(done1)
    );

    tdm_line_mux #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .L(L3),
        .P(P3), .LB(LB3), .valid(valid3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic [1:0] lb, input logic p,
                        input logic v, input logic b, input logic d);
        chk({nm, " LB"}, {2'b00, LB1}, {2'b00, lb});
        chk({nm, " P"}, {3'b000, P1}, {3'b000, p});
        chk({nm, " valid"}, {3'b000, valid1}, {3'b000, v});
        chk({nm, " busy"}, {3'b000, busy1}, {3'b000, b});
        chk({nm, " done"}, {3'b000, done1}, {3'b000, d});
    endtask

    task automatic set_vec(input int i, input logic s, input logic [0:3] l, input logic [1:0] lb,
                           input logic p, input logic v, input logic b, input logic d);
        vt[i].start = s;  vt[i].l = l;    vt[i].lb = lb; vt[i].p = p;
        vt[i].valid = v;  vt[i].busy = b; vt[i].done = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3] pat;
        int         vcount;
        int         ph;

        // basic frame L=1010, then IDLE
        set_vec(0,  1'b1, 4'b1010, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(1,  1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        set_vec(2,  1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(3,  1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        set_vec(4,  1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        set_vec(5,  1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // snapshot: L drops to 0 after capture, start during SEND/DONE ignored
        set_vec(6,  1'b1, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(7,  1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(8,  1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(9,  1'b1, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(10, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        set_vec(11, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_vec(12, 1'b1, 4'b0110, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        set_vec(13, 1'b1, 4'b0110, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(14, 1'b0, 4'b0110, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(15, 1'b0, 4'b0110, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        set_vec(16, 1'b0, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        set_vec(17, 1'b0, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; L1 = 4'b0000; L3 = 4'b0000;
        #1;
        chk1("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset busy3", {3'b000, busy3}, 4'h0);
        step();
        step();
        rst_n = 1'b1;

`ifndef LINE_MUX_AUTO_EN
        // row 0 starts on the first edge after reset release
        foreach (vt[i]) begin
            start1 = vt[i].start;
            L1     = vt[i].l;
            step();
            chk1($sformatf("row%0d", i), vt[i].lb, vt[i].p, vt[i].valid, vt[i].busy, vt[i].done);
        end

        // start held high: 4 SEND, 1 DONE, 1 IDLE, repeating every 6 cycles
        start1 = 1'b1;
        L1     = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            ph = c % 6;
            chk1($sformatf("held c%0d", c), (ph < 4) ? 2'(ph) : 2'd0, ph < 4, ph < 4,
                 ph != 5, ph == 4);
        end
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("held drain busy", {3'b000, busy1}, 4'h0);
`else
        // continuous scanning: one start pulse, L changed while DONE is showing
        start1 = 1'b1;
        L1     = 4'b1010;
        pat    = 4'b1010;
        for (int c = 0; c < 15; c++) begin
            step();
            start1 = 1'b0;
            ph = c % 5;
            chk1($sformatf("auto c%0d", c), (ph < 4) ? 2'(ph) : 2'd0, (ph < 4) ? pat[ph] : 1'b0,
                 ph < 4, 1'b1, ph == 4);
            if (ph == 4) begin
                pat = ~pat;
                L1  = pat;
            end
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
`endif

        // HOLD_CYCLES=3: each slot held 3 cycles, 12 valid cycles, P 0,1,1,0
        pat    = 4'b0110;
        start3 = 1'b1;
        L3     = pat;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            start3 = 1'b0;
            L3     = 4'b1001;
            if (valid3) vcount++;
            chk($sformatf("h3 i%0d LB", i), {2'b00, LB3}, 4'(i / 3));
            chk($sformatf("h3 i%0d P", i), {3'b000, P3}, {3'b000, pat[i / 3]});
        end
        step();
        chk("h3 valid count", 4'(vcount), 4'd12);
        chk("h3 done", {3'b000, done3}, 4'h1);
        chk("h3 done valid", {3'b000, valid3}, 4'h0);

        // asynchronous reset mid-frame at LB=2, then fresh frame after release
        start1 = 1'b1;
        L1     = 4'b1010;
        step();
        start1 = 1'b0;
        step();
        step();
        chk("pre-reset LB", {2'b00, LB1}, 4'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("async reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk1("reset held", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        start1 = 1'b1;
        L1     = 4'b0101;
        step();
        start1 = 1'b0;
        chk1("post-reset slot0", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk1("post-reset slot1", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_line_mux.md
TDM_LINE_MUX -- requirements
Module: tdm_line_mux

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; no other clock or reset input.
REQ-002 Parameter HOLD_CYCLES, default 1, SHALL set the clock cycles each slot is driven; legal range 1..16.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port start, input, 1, SHALL be the frame request, sampled on clk rising edge.
REQ-006 Port L, input, 4 (L[0:3]), SHALL carry the four line values to be multiplexed.
REQ-007 Port P, output, 1, SHALL carry the serialized value of the selected line.
REQ-008 Port LB, output, 2 (LB[1:0]), SHALL carry the binary index of the line currently driven on P.
REQ-009 Port valid, output, 1, SHALL be high in every cycle where P/LB form a legal slot.
REQ-010 Port busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-011 Port done, output, 1, SHALL pulse high for exactly one cycle at frame end.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-013 IDLE: P=0, LB=0, valid=0, done=0; on a sampled start=1, all four L bits SHALL be captured into a 4-bit snapshot, slot index cleared to 0, hold counter cleared, next state SEND.
REQ-014 Latency: with start sampled at edge k, valid=1 and LB=0 SHALL appear in the cycle after edge k.
REQ-015 SEND: P SHALL equal snapshot[LB], valid=1; L changes after capture SHALL NOT affect the frame.
REQ-016 Each slot SHALL persist exactly HOLD_CYCLES cycles; then LB increments by 1.
REQ-017 Slot order SHALL be 0,1,2,3; after slot 3's final hold cycle the next state SHALL be DONE, with no wrap back to slot 0.
REQ-018 A frame SHALL have exactly 4*HOLD_CYCLES valid cycles.
REQ-019 DONE: done=1, valid=0, P=0, LB=0 for one cycle; next state IDLE.
REQ-020 start SHALL be ignored in SEND and DONE; no queuing of requests.
REQ-021 start held high continuously SHALL launch a new frame on the first IDLE cycle, one cycle after done.
REQ-022 The hold counter SHALL be 4 bits wide and count 0..HOLD_CYCLES-1 without overflow.

Reset
REQ-023 rst_n=0 SHALL force immediately, without waiting for clk: state=IDLE, snapshot=0, LB=0, hold counter=0, P=0, valid=0, busy=0, done=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after release begins a fresh frame at slot 0.
REQ-025 start sampled on the first clk edge after rst_n rises SHALL be honored.

Configuration
REQ-026 Macro LINE_MUX_AUTO_EN SHALL control continuous scanning.
REQ-027 With LINE_MUX_AUTO_EN defined: DONE SHALL go directly to SEND, recapturing L, regardless of start; the first frame after reset still requires start; done still pulses one cycle between frames.
REQ-028 Without LINE_MUX_AUTO_EN: behaviour SHALL be exactly REQ-012..REQ-022.

Verification
REQ-029 Reset: rst_n=0 mid-frame at LB=2, no clk edge -> P=0, LB=0, valid=0, busy=0, done=0 immediately.
REQ-030 HOLD_CYCLES=1, L=4'b1010 (L[0]=1,L[1]=0,L[2]=1,L[3]=0), start 1 cycle -> (LB,P)=(0,1),(1,0),(2,1),(3,0) on consecutive cycles, then done=1 for one cycle, then IDLE.
REQ-031 HOLD_CYCLES=3, L=4'b0110 -> each LB value held 3 cycles, 12 valid cycles total, P sequence 0,1,1,0.
REQ-032 Snapshot: start with L=4'b1111, L driven to 4'b0000 one cycle later -> P=1 for all four slots.
REQ-033 start held high for 20 cycles, HOLD_CYCLES=1 -> 4 valid cycles, 1 done cycle, 1 IDLE cycle, repeating every 6 cycles; no double launch.
REQ-034 LINE_MUX_AUTO_EN defined, one start pulse, L toggled between frames -> back-to-back frames every 5 cycles, each frame reflecting L captured at its DONE-to-SEND transition.
